alu_rs_sched: RTL and testbench

//  ALU reservation station and issue scheduler. Buffers dispatched ALU ops and snoops two CDB ports to wake pending operands.

---
 rtl/alu_rs_sched_pkg.sv | 74 +++++++
 rtl/alu_rs_sched_rr_pick.sv | 28 ++
 rtl/alu_rs_sched.sv | 144 ++++++++++++++
 tb/tb_alu_rs_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_sched_pkg.sv
// Shared widths, tag encodings, opcodes and payload structs for the ALU reservation station.
package alu_rs_sched_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned NAME_W = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned ADDR_W = 32;

  localparam logic [TAG_W-1:0]  TAG_FREE  = '1;
  localparam logic [DATA_W-1:0] DATA_FREE = '0;
  localparam logic [NAME_W-1:0] NAME_FREE = '0;
  localparam logic [ADDR_W-1:0] ADDR_FREE = '0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 6'd0,
    OP_SUB   = 6'd1,
    OP_AND   = 6'd2,
    OP_OR    = 6'd3,
    OP_XOR   = 6'd4,
    OP_SLL   = 6'd5,
    OP_SRL   = 6'd6,
    OP_SRA   = 6'd7,
    OP_SLT   = 6'd8,
    OP_SLTU  = 6'd9,
    OP_LUI   = 6'd10,
    OP_AUIPC = 6'd11
  } alu_op_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } operand_t;

  typedef struct packed {
    logic              en;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    operand_t          src1;
    operand_t          src2;
    logic [TAG_W-1:0]  dest;
    logic [NAME_W-1:0] name;
    logic [ADDR_W-1:0] addr;
  } rs_entry_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] val1;
    logic [DATA_W-1:0] val2;
    logic [TAG_W-1:0]  dest;
    logic [NAME_W-1:0] name;
    logic [ADDR_W-1:0] addr;
  } issue_t;

  // Capture a broadcast result into a pending operand; port A has priority, TAG_FREE never matches.
  function automatic operand_t snoop(input operand_t opnd, input cdb_t a, input cdb_t b);
    operand_t res;
    res = opnd;
    if (opnd.tag != TAG_FREE) begin
      if (a.en && (a.tag == opnd.tag)) begin
        res = '{tag: TAG_FREE, val: a.data};
      end else if (b.en && (b.tag == opnd.tag)) begin
        res = '{tag: TAG_FREE, val: b.data};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_sched_rr_pick.sv
// Rotating-priority picker: first set bit of ready at or above ptr, wrapping around.
module alu_rs_sched_rr_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]                           ready_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   ptr_i,
  output logic [N-1:0]                           grant_c,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]   idx_c,
  output logic                                   any_c
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  // N is a power of two, so IDX_W-bit addition wraps modulo N.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_c && ready_i[ptr_i + IDX_W'(i)]) begin
        any_c                        = 1'b1;
        idx_c                        = ptr_i + IDX_W'(i);
        grant_c[ptr_i + IDX_W'(i)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs_sched.sv
// ALU reservation station: buffers dispatched ops, wakes operands from two CDB ports,
// and issues one ready entry per cycle to the ALU through registered outputs.
module alu_rs_sched
  import alu_rs_sched_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispEn,
  input  logic [OP_W-1:0]   dispOp,
  input  logic [DATA_W-1:0] dispVal1,
  input  logic [TAG_W-1:0]  dispTag1,
  input  logic [DATA_W-1:0] dispVal2,
  input  logic [TAG_W-1:0]  dispTag2,
  input  logic [TAG_W-1:0]  dispDest,
  input  logic [NAME_W-1:0] dispName,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic              rsFull,
  input  logic              cdbAEn,
  input  logic [TAG_W-1:0]  cdbATag,
  input  logic [DATA_W-1:0] cdbAData,
  input  logic              cdbBEn,
  input  logic [TAG_W-1:0]  cdbBTag,
  input  logic [DATA_W-1:0] cdbBData,
  output logic              ALUworkEn,
  output logic [DATA_W-1:0] operandO,
  output logic [DATA_W-1:0] operandT,
  output logic [TAG_W-1:0]  wrtTag,
  output logic [NAME_W-1:0] wrtName,
  output logic [OP_W-1:0]   opCode,
  output logic [ADDR_W-1:0] instAddr
);

  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam issue_t ISSUE_RESET = '{op: '0, val1: DATA_FREE, val2: DATA_FREE,
                                     dest: TAG_FREE, name: NAME_FREE, addr: ADDR_FREE};

  rs_entry_t           entries_q [RS_DEPTH];
  rs_entry_t           entries_d [RS_DEPTH];
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                alu_en_q, alu_en_d;
  issue_t              issue_q, issue_d;

  logic [RS_DEPTH-1:0] valid_c, ready_c, grant_c;
  logic [IDX_W-1:0]    pick_idx_c, free_idx_c;
  logic                pick_any_c;
  cdb_t                cdb_a, cdb_b;
  operand_t            disp_src1_c, disp_src2_c;

  assign cdb_a = '{en: cdbAEn, tag: cdbATag, data: cdbAData};
  assign cdb_b = '{en: cdbBEn, tag: cdbBTag, data: cdbBData};

  assign disp_src1_c = snoop(operand_t'{tag: dispTag1, val: dispVal1}, cdb_a, cdb_b);
  assign disp_src2_c = snoop(operand_t'{tag: dispTag2, val: dispVal2}, cdb_a, cdb_b);

  // Eligibility uses start-of-cycle state; same-cycle wakeups count from the next cycle.
  always_comb begin
    valid_c = '0;
    ready_c = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      valid_c[i] = entries_q[i].valid;
      ready_c[i] = entries_q[i].valid && (entries_q[i].src1.tag == TAG_FREE)
                   && (entries_q[i].src2.tag == TAG_FREE);
    end
  end

  // Lowest-index free slot; downward scan leaves the lowest match last.
  always_comb begin
    free_idx_c = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_c[i]) free_idx_c = IDX_W'(i);
    end
  end

  assign rsFull = &valid_c;

  alu_rs_sched_rr_pick #(.N(RS_DEPTH)) u_pick (
    .ready_i (ready_c),
    .ptr_i   (ptr_q),
    .grant_c (grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    alu_en_d  = 1'b0;
    issue_d   = issue_q;
    if (flush) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entries_d[i] = '0;
      ptr_d   = '0;
      issue_d = ISSUE_RESET;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (entries_q[i].valid) begin
          entries_d[i].src1 = snoop(entries_q[i].src1, cdb_a, cdb_b);
          entries_d[i].src2 = snoop(entries_q[i].src2, cdb_a, cdb_b);
        end
        if (grant_c[i]) entries_d[i].valid = 1'b0;
      end
      // The free slot is never the issuing slot, so both can happen in one cycle.
      if (dispEn && !rsFull) begin
        entries_d[free_idx_c] = '{valid: 1'b1, op: dispOp, src1: disp_src1_c, src2: disp_src2_c,
                                  dest: dispDest, name: dispName, addr: dispAddr};
      end
      if (pick_any_c) begin
        alu_en_d = 1'b1;
        ptr_d    = pick_idx_c + IDX_W'(1);
        issue_d  = '{op:   entries_q[pick_idx_c].op,
                     val1: entries_q[pick_idx_c].src1.val,
                     val2: entries_q[pick_idx_c].src2.val,
                     dest: entries_q[pick_idx_c].dest,
                     name: entries_q[pick_idx_c].name,
                     addr: entries_q[pick_idx_c].addr};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entries_q[i] <= '0;
      ptr_q    <= '0;
      alu_en_q <= 1'b0;
      issue_q  <= ISSUE_RESET;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) entries_q[i] <= entries_d[i];
      ptr_q    <= ptr_d;
      alu_en_q <= alu_en_d;
      issue_q  <= issue_d;
    end
  end

  assign ALUworkEn = alu_en_q;
  assign operandO  = issue_q.val1;
  assign operandT  = issue_q.val2;
  assign wrtTag    = issue_q.dest;
  assign wrtName   = issue_q.name;
  assign opCode    = issue_q.op;
  assign instAddr  = issue_q.addr;

endmodule

// File: tb/tb_alu_rs_sched.sv
// Self-checking bench for alu_rs_sched: directed scenarios plus randomized traffic against a slot-level model.
module tb_alu_rs_sched;
  import alu_rs_sched_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, dispEn, cdbAEn, cdbBEn;
  logic [OP_W-1:0]   dispOp;
  logic [DATA_W-1:0] dispVal1, dispVal2, cdbAData, cdbBData;
  logic [TAG_W-1:0]  dispTag1, dispTag2, dispDest, cdbATag, cdbBTag;
  logic [NAME_W-1:0] dispName;
  logic [ADDR_W-1:0] dispAddr;
  logic              rsFull, ALUworkEn;
  logic [DATA_W-1:0] operandO, operandT;
  logic [TAG_W-1:0]  wrtTag;
  logic [NAME_W-1:0] wrtName;
  logic [OP_W-1:0]   opCode;
  logic [ADDR_W-1:0] instAddr;

  alu_rs_sched #(.RS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dispEn(dispEn), .dispOp(dispOp),
    .dispVal1(dispVal1), .dispTag1(dispTag1), .dispVal2(dispVal2), .dispTag2(dispTag2),
    .dispDest(dispDest), .dispName(dispName), .dispAddr(dispAddr), .rsFull(rsFull),
    .cdbAEn(cdbAEn), .cdbATag(cdbATag), .cdbAData(cdbAData),
    .cdbBEn(cdbBEn), .cdbBTag(cdbBTag), .cdbBData(cdbBData),
    .ALUworkEn(ALUworkEn), .operandO(operandO), .operandT(operandT), .wrtTag(wrtTag),
    .wrtName(wrtName), .opCode(opCode), .instAddr(instAddr)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a table of slots plus the rotating start position.
  logic              m_v    [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [DATA_W-1:0] m_d1   [DEPTH];
  logic [DATA_W-1:0] m_d2   [DEPTH];
  logic [TAG_W-1:0]  m_t1   [DEPTH];
  logic [TAG_W-1:0]  m_t2   [DEPTH];
  logic [TAG_W-1:0]  m_dest [DEPTH];
  logic [NAME_W-1:0] m_name [DEPTH];
  logic [ADDR_W-1:0] m_addr [DEPTH];
  int                m_ptr;
  logic              e_en;
  logic [DATA_W-1:0] e_o, e_t;
  logic [TAG_W-1:0]  e_tag;
  logic [NAME_W-1:0] e_name;
  logic [OP_W-1:0]   e_op;
  logic [ADDR_W-1:0] e_addr;

  function automatic logic model_full();
    for (int i = 0; i < DEPTH; i++) if (!m_v[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_ptr = 0;
    e_en = 1'b0; e_o = '0; e_t = '0; e_tag = TAG_FREE; e_name = '0; e_op = '0; e_addr = '0;
  endtask

  task automatic resolve(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d,
                         output logic [TAG_W-1:0] to, output logic [DATA_W-1:0] dout);
    to = t; dout = d;
    if (t != TAG_FREE) begin
      if (cdbAEn && cdbATag == t) begin to = TAG_FREE; dout = cdbAData; end
      else if (cdbBEn && cdbBTag == t) begin to = TAG_FREE; dout = cdbBData; end
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int win, slot;
    logic full;
    if (rst || flush) begin model_clear(); return; end
    win = -1; slot = -1; full = model_full();
    for (int i = 0; i < DEPTH; i++) begin
      int k;
      k = (m_ptr + i) % DEPTH;
      if (win < 0 && m_v[k] && m_t1[k] == TAG_FREE && m_t2[k] == TAG_FREE) win = k;
    end
    for (int i = 0; i < DEPTH; i++) if (slot < 0 && !m_v[i]) slot = i;
    e_en = (win >= 0);
    if (win >= 0) begin
      e_o = m_d1[win]; e_t = m_d2[win]; e_tag = m_dest[win];
      e_name = m_name[win]; e_op = m_op[win]; e_addr = m_addr[win];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i]) begin
        resolve(m_t1[i], m_d1[i], m_t1[i], m_d1[i]);
        resolve(m_t2[i], m_d2[i], m_t2[i], m_d2[i]);
      end
    end
    if (win >= 0) begin m_v[win] = 1'b0; m_ptr = (win + 1) % DEPTH; end
    if (dispEn && !full) begin
      m_v[slot] = 1'b1; m_op[slot] = dispOp; m_dest[slot] = dispDest;
      m_name[slot] = dispName; m_addr[slot] = dispAddr;
      resolve(dispTag1, dispVal1, m_t1[slot], m_d1[slot]);
      resolve(dispTag2, dispVal2, m_t2[slot], m_d2[slot]);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; dispEn = 1'b0; dispOp = '0;
    dispVal1 = '0; dispTag1 = TAG_FREE; dispVal2 = '0; dispTag2 = TAG_FREE;
    dispDest = '0; dispName = '0; dispAddr = '0;
    cdbAEn = 1'b0; cdbATag = TAG_FREE; cdbAData = '0;
    cdbBEn = 1'b0; cdbBTag = TAG_FREE; cdbBData = '0;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [DATA_W-1:0] v1,
                          input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v2,
                          input logic [TAG_W-1:0] t2, input logic [TAG_W-1:0] dest);
    dispEn = 1'b1; dispOp = op; dispVal1 = v1; dispTag1 = t1; dispVal2 = v2; dispTag2 = t2;
    dispDest = dest; dispName = NAME_W'(dest) + 5'd1; dispAddr = 32'h1000 + ADDR_W'(dest) * 4;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step(); step(); rst = 1'b0;
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL reset_en: got %0b want 0", ALUworkEn); end
    n_cmp++; if (rsFull !== 1'b0) begin n_mis++; $display("FAIL reset_full: got %0b want 0", rsFull); end
    n_cmp++; if (wrtTag !== TAG_FREE) begin n_mis++; $display("FAIL reset_tag: got %0h want f", wrtTag); end
    n_cmp++; if (operandO !== 32'd0) begin n_mis++; $display("FAIL reset_opnd: got %0h want 0", operandO); end
    for (int i = 0; i < 3; i++) begin set_disp(OP_ADD, 0, 4'd7, 1, TAG_FREE, TAG_W'(i)); step(); end
    set_disp(OP_OR, 32'h22, TAG_FREE, 32'h33, TAG_FREE, 4'd4); step();
    idle(); step();
    n_cmp++; if (ALUworkEn !== 1'b1 || wrtTag !== 4'd4) begin n_mis++; $display("FAIL midop_issue: got en=%0b tag=%0h want en=1 tag=4", ALUworkEn, wrtTag); end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL midop_rst_en: got %0b want 0", ALUworkEn); end
    n_cmp++; if (rsFull !== 1'b0) begin n_mis++; $display("FAIL midop_rst_full: got %0b want 0", rsFull); end
    n_cmp++; if (wrtTag !== TAG_FREE || opCode !== '0) begin n_mis++; $display("FAIL midop_rst_regs: got tag=%0h op=%0h want f/0", wrtTag, opCode); end
    cdbAEn = 1'b1; cdbATag = 4'd7; cdbAData = 32'h77; step(); idle();
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL midop_stale_issue: got %0b want 0", ALUworkEn); end
    end
  endtask

  task automatic test_ready_dispatch();
    idle(); set_disp(OP_ADD, 32'd5, TAG_FREE, 32'd7, TAG_FREE, 4'd3); step(); idle();
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL add_early: got %0b want 0", ALUworkEn); end
    step();
    n_cmp++; if (ALUworkEn !== 1'b1 || operandO !== 32'd5 || operandT !== 32'd7) begin n_mis++; $display("FAIL add_issue: got en=%0b o=%0d t=%0d want 1/5/7", ALUworkEn, operandO, operandT); end
    n_cmp++; if (wrtTag !== 4'd3 || opCode !== OP_ADD || wrtName !== 5'd4 || instAddr !== 32'h100c) begin n_mis++; $display("FAIL add_meta: got tag=%0h op=%0h name=%0h addr=%0h want 3/0/4/100c", wrtTag, opCode, wrtName, instAddr); end
    step();
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL add_one_cycle: got %0b want 0", ALUworkEn); end
  endtask

  task automatic test_cdb_wakeup();
    idle(); set_disp(OP_SUB, 32'd0, 4'd2, 32'd1, TAG_FREE, 4'd5); step(); idle();
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin cdbAEn = 1'b1; cdbATag = 4'd2; cdbAData = 32'h10; end
      n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL wake_early%0d: got %0b want 0", i, ALUworkEn); end
      step();
    end
    idle();
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL wake_same_cycle: got %0b want 0", ALUworkEn); end
    step();
    n_cmp++; if (ALUworkEn !== 1'b1 || operandO !== 32'h10 || operandT !== 32'd1 || wrtTag !== 4'd5) begin n_mis++; $display("FAIL wake_issue: got en=%0b o=%0h t=%0h tag=%0h want 1/10/1/5", ALUworkEn, operandO, operandT, wrtTag); end
  endtask

  task automatic test_dispatch_bypass();
    idle(); set_disp(OP_XOR, 32'd0, 4'd6, 32'd3, TAG_FREE, 4'd6);
    cdbBEn = 1'b1; cdbBTag = 4'd6; cdbBData = 32'd9; step(); idle();
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL bypass_early: got %0b want 0", ALUworkEn); end
    step();
    n_cmp++; if (ALUworkEn !== 1'b1 || operandO !== 32'd9 || operandT !== 32'd3 || wrtTag !== 4'd6) begin n_mis++; $display("FAIL bypass_issue: got en=%0b o=%0h t=%0h tag=%0h want 1/9/3/6", ALUworkEn, operandO, operandT, wrtTag); end
  endtask

  task automatic test_fill_rotate();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin set_disp(OP_AND, 32'd0, 4'd1, DATA_W'(i), TAG_FREE, TAG_W'(i)); step(); end
    idle();
    n_cmp++; if (rsFull !== 1'b1) begin n_mis++; $display("FAIL fill_full: got %0b want 1", rsFull); end
    set_disp(OP_ADD, 32'hdead, TAG_FREE, 32'hbeef, TAG_FREE, 4'd9); step(); idle();
    n_cmp++; if (rsFull !== 1'b1 || ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL fill_overflow: got full=%0b en=%0b want 1/0", rsFull, ALUworkEn); end
    cdbAEn = 1'b1; cdbATag = 4'd1; cdbAData = 32'h100; step(); idle();
    n_cmp++; if (rsFull !== 1'b1) begin n_mis++; $display("FAIL fill_full_at_issue: got %0b want 1", rsFull); end
    for (int i = 0; i < DEPTH; i++) begin
      step();
      n_cmp++; if (ALUworkEn !== 1'b1 || wrtTag !== TAG_W'(i) || operandO !== 32'h100 || operandT !== DATA_W'(i)) begin n_mis++; $display("FAIL rotate%0d: got en=%0b tag=%0h o=%0h t=%0h want 1/%0h/100/%0h", i, ALUworkEn, wrtTag, operandO, operandT, i, i); end
    end
    step();
    n_cmp++; if (ALUworkEn !== 1'b0 || rsFull !== 1'b0) begin n_mis++; $display("FAIL fill_drained: got en=%0b full=%0b want 0/0", ALUworkEn, rsFull); end
  endtask

  task automatic test_flush();
    idle();
    for (int i = 0; i < 4; i++) begin set_disp(OP_SLT, 32'd0, 4'd5, 32'd2, TAG_FREE, TAG_W'(i)); step(); end
    idle(); flush = 1'b1; set_disp(OP_ADD, 32'd1, TAG_FREE, 32'd1, TAG_FREE, 4'd12); step(); idle();
    n_cmp++; if (ALUworkEn !== 1'b0 || rsFull !== 1'b0 || wrtTag !== TAG_FREE) begin n_mis++; $display("FAIL flush_state: got en=%0b full=%0b tag=%0h want 0/0/f", ALUworkEn, rsFull, wrtTag); end
    step();
    n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL flush_drop_disp: got %0b want 0", ALUworkEn); end
    cdbAEn = 1'b1; cdbATag = 4'd5; cdbAData = 32'h55; step(); idle();
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (ALUworkEn !== 1'b0) begin n_mis++; $display("FAIL flush_pending_gone: got %0b want 0", ALUworkEn); end
    end
  endtask

  task automatic test_random();
    idle(); rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 149) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      dispEn   = model_full() ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 60);
      dispOp   = OP_W'($urandom_range(0, 11));
      dispVal1 = $urandom; dispVal2 = $urandom;
      dispTag1 = ($urandom_range(0, 2) == 0) ? TAG_FREE : TAG_W'($urandom_range(0, 5));
      dispTag2 = ($urandom_range(0, 2) == 0) ? TAG_FREE : TAG_W'($urandom_range(0, 5));
      dispDest = TAG_W'($urandom_range(0, 14)); dispName = NAME_W'($urandom); dispAddr = $urandom;
      cdbAEn   = ($urandom_range(0, 2) == 0); cdbAData = $urandom;
      cdbATag  = ($urandom_range(0, 7) == 0) ? TAG_FREE : TAG_W'($urandom_range(0, 5));
      cdbBEn   = ($urandom_range(0, 2) == 0); cdbBData = $urandom;
      cdbBTag  = ($urandom_range(0, 7) == 0) ? TAG_FREE : TAG_W'($urandom_range(0, 5));
      n_cmp++; if (rsFull !== model_full()) begin n_mis++; $display("FAIL rnd_full c%0d: got %0b want %0b", c, rsFull, model_full()); end
      step();
      n_cmp++; if (ALUworkEn !== e_en) begin n_mis++; $display("FAIL rnd_en c%0d: got %0b want %0b", c, ALUworkEn, e_en); end
      n_cmp++; if (operandO !== e_o || operandT !== e_t) begin n_mis++; $display("FAIL rnd_opnd c%0d: got %0h/%0h want %0h/%0h", c, operandO, operandT, e_o, e_t); end
      n_cmp++; if (wrtTag !== e_tag || wrtName !== e_name || opCode !== e_op || instAddr !== e_addr) begin n_mis++; $display("FAIL rnd_meta c%0d: got %0h/%0h/%0h/%0h want %0h/%0h/%0h/%0h", c, wrtTag, wrtName, opCode, instAddr, e_tag, e_name, e_op, e_addr); end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_clear();
    test_reset();
    test_ready_dispatch();
    test_cdb_wakeup();
    test_dispatch_bypass();
    test_fill_rotate();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
